// File: rtl/mul_arb.sv
// Round-robin arbiter that shares one two-stage multiplier between the core MDU (id 0)
// and a coprocessor port (id 1). It tracks the single in-flight op and returns its result half.
module mul_arb #(
  parameter int XLEN = 64
) (
  input  logic [0:0]        clk,
  input  logic [0:0]        reset,
  input  logic [1:0]        ReqValid,
  output logic [1:0]        ReqReady,
  input  logic [XLEN-1:0]   ReqSrcA0,
  input  logic [XLEN-1:0]   ReqSrcB0,
  input  logic [XLEN-1:0]   ReqSrcA1,
  input  logic [XLEN-1:0]   ReqSrcB1,
  input  logic [2:0]        ReqFunct3_0,
  input  logic [2:0]        ReqFunct3_1,
  input  logic [1:0]        Flush,
  output logic [1:0]        RespValid,
  input  logic [1:0]        RespReady,
  output logic [XLEN-1:0]   RespData,
  output logic [XLEN-1:0]   MulSrcA,
  output logic [XLEN-1:0]   MulSrcB,
  output logic [2:0]        MulFunct3,
  output logic              MulStallM,
  output logic              MulFlushM,
  input  logic [2*XLEN-1:0] MulProdM
);

  logic       vld_p1, id_p1, hi_p1, ptr;
  logic       kill, accept, advance, sel;
  logic [1:0] eligible, grant;

  function automatic logic [XLEN-1:0] select_half(input logic hi, input logic [2*XLEN-1:0] prod);
    return hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  endfunction

  assign kill     = vld_p1 & Flush[id_p1];
  assign accept   = vld_p1 & ~kill & RespReady[id_p1];
  assign advance  = ~vld_p1 | kill | accept;
  assign eligible = ReqValid & ~Flush;

  // No grant while reset is held, so ReqReady stays low throughout reset.
  always_comb begin
    grant = 2'b00;
    if (advance && reset[0]) begin
      if (eligible == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                   grant = eligible;
    end
  end

  assign sel       = (grant == 2'b00) ? ptr : grant[1];
  assign ReqReady  = grant;
  assign MulSrcA   = sel ? ReqSrcA1 : ReqSrcA0;
  assign MulSrcB   = sel ? ReqSrcB1 : ReqSrcB0;
  assign MulFunct3 = sel ? ReqFunct3_1 : ReqFunct3_0;

  // Flush only when an occupied slot drains with nothing behind it; an idle
  // multiplier's Memory stage is ignored anyway because the slot is empty.
  assign MulStallM = ~advance;
  assign MulFlushM = advance & ~(|grant) & vld_p1;

  // Execute -> Memory boundary: the slot mirrors the op held in the multiplier's M stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
      hi_p1  <= 1'b0;
      ptr    <= 1'b0;
    end else begin
      if (|grant) begin
        ptr   <= ~sel;
        id_p1 <= sel;
        hi_p1 <= (MulFunct3 != 3'b000);
      end
      if (advance) vld_p1 <= |grant;
    end
  end

  assign RespValid = {vld_p1 & ~kill & id_p1, vld_p1 & ~kill & ~id_p1};
  assign RespData  = select_half(hi_p1, MulProdM);

endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb at XLEN=32 with a behavioural two-stage multiplier
// whose Memory-stage product register obeys MulStallM/MulFlushM.
module tb_mul_arb;
  localparam int XLEN = 32;

  logic [0:0]        clk = 1'b0;
  logic [0:0]        reset;
  logic [1:0]        req_valid, req_ready, flush, resp_valid, resp_ready;
  logic [XLEN-1:0]   a0, b0, a1, b1, resp_data, mul_a, mul_b;
  logic [2:0]        f3_0, f3_1, mul_f3;
  logic              mul_stall, mul_flush;
  logic [2*XLEN-1:0] prod_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqSrcA0(a0), .ReqSrcB0(b0), .ReqSrcA1(a1), .ReqSrcB1(b1),
    .ReqFunct3_0(f3_0), .ReqFunct3_1(f3_1), .Flush(flush),
    .RespValid(resp_valid), .RespReady(resp_ready), .RespData(resp_data),
    .MulSrcA(mul_a), .MulSrcB(mul_b), .MulFunct3(mul_f3),
    .MulStallM(mul_stall), .MulFlushM(mul_flush), .MulProdM(prod_m)
  );

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3);
    logic signed [63:0] sa, sb;
    sa = (f3[1:0] == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
    sb = (f3[1:0] == 2'b00 || f3[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (mul_flush)      prod_m <= '0;
    else if (!mul_stall) prod_m <= mul_model(mul_a, mul_b, mul_f3);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; flush = 2'b00; resp_ready = 2'b11;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; f3_0 = 3'b000; f3_1 = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    req_valid = 2'b11;
    step();
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=00", resp_valid); end
    n_checks++; if (mul_stall !== 1'b0 || mul_flush !== 1'b0) begin n_fail++; $display("FAIL rst_ctl got=%b%b exp=00", mul_stall, mul_flush); end
    step();
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL post_rst got=%b/%b exp=00/00", req_ready, resp_valid); end
    n_checks++; if (mul_stall !== 1'b0 || mul_flush !== 1'b0) begin n_fail++; $display("FAIL post_rst_ctl got=%b%b exp=00", mul_stall, mul_flush); end
    step();
  endtask

  task automatic test_mul_low();
    req_valid = 2'b01; a0 = 32'd7; b0 = 32'hFFFF_FFFD; f3_0 = 3'b000;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mul_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL mul_rvalid got=%b exp=01", resp_valid); end
    n_checks++; if (resp_data !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_data got=%h exp=ffffffeb", resp_data); end
    n_checks++; if (mul_flush !== 1'b1) begin n_fail++; $display("FAIL mul_flushm got=%b exp=1", mul_flush); end
    step();
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL mul_drain got=%b exp=00", resp_valid); end
    step();
  endtask

  task automatic test_mul_high();
    req_valid = 2'b10; a1 = 32'h8000_0000; b1 = 32'h8000_0000; f3_1 = 3'b001;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mulh_ready got=%b exp=10", req_ready); end
    step();
    a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; f3_1 = 3'b011;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b10 || resp_data !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_resp got=%b/%h exp=10/40000000", resp_valid, resp_data); end
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mulhu_ready got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b10 || resp_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_resp got=%b/%h exp=10/fffffffe", resp_valid, resp_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ready [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0]  exp_resp  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_data  [5] = '{32'd0, 32'd15, 32'd42, 32'd15, 32'd42};
    a0 = 32'd3; b0 = 32'd5; f3_0 = 3'b000;
    a1 = 32'd6; b1 = 32'd7; f3_1 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_ready[i] || resp_valid !== exp_resp[i] ||
          (exp_resp[i] != 2'b00 && resp_data !== exp_data[i])) begin
        n_fail++;
        $display("FAIL b2b[%0d] got=%b/%b/%0d exp=%b/%b/%0d", i, req_ready, resp_valid, resp_data,
                 exp_ready[i], exp_resp[i], exp_data[i]);
      end
      step();
    end
  endtask

  task automatic test_stall();
    req_valid = 2'b01; a0 = 32'd9; b0 = 32'd11; f3_0 = 3'b000; resp_ready = 2'b10;
    a1 = 32'd4; b1 = 32'd5; f3_1 = 3'b000;
    step();
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (mul_stall !== 1'b1 || req_ready !== 2'b00 || resp_valid !== 2'b01 || resp_data !== 32'd99) begin
        n_fail++;
        $display("FAIL stall[%0d] got=%b/%b/%b/%0d exp=1/00/01/99", i, mul_stall, req_ready, resp_valid, resp_data);
      end
      step();
    end
    resp_ready = 2'b11;
    @(negedge clk);
    n_checks++;
    if (mul_stall !== 1'b0 || req_ready !== 2'b10 || resp_valid !== 2'b01 || resp_data !== 32'd99) begin
      n_fail++;
      $display("FAIL stall_release got=%b/%b/%b/%0d exp=0/10/01/99", mul_stall, req_ready, resp_valid, resp_data);
    end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b10 || resp_data !== 32'd20) begin n_fail++; $display("FAIL stall_next got=%b/%0d exp=10/20", resp_valid, resp_data); end
    step();
  endtask

  task automatic test_flush();
    req_valid = 2'b01; a0 = 32'd2; b0 = 32'd8; f3_0 = 3'b000;
    a1 = 32'd5; b1 = 32'd5; f3_1 = 3'b000;
    step();
    req_valid = 2'b10; flush = 2'b01;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin n_fail++; $display("FAIL kill_regrant got=%b/%b exp=00/10", resp_valid, req_ready); end
    n_checks++; if (mul_stall !== 1'b0 || mul_flush !== 1'b0) begin n_fail++; $display("FAIL kill_ctl got=%b%b exp=00", mul_stall, mul_flush); end
    step();
    req_valid = 2'b00; flush = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b10 || resp_data !== 32'd25) begin n_fail++; $display("FAIL kill_next got=%b/%0d exp=10/25", resp_valid, resp_data); end
    step();
    req_valid = 2'b01; a0 = 32'd12; b0 = 32'd12;
    step();
    flush = 2'b01;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00 || mul_flush !== 1'b1) begin n_fail++; $display("FAIL kill_empty got=%b/%b/%b exp=00/00/1", resp_valid, req_ready, mul_flush); end
    step();
    req_valid = 2'b00; flush = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL kill_silent got=%b exp=00", resp_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; a0 = 32'd3; b0 = 32'd3; f3_0 = 3'b000;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_issue got=%b exp=01", req_ready); end
    step();
    reset = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rmid_drop got=%b/%b exp=00/00", resp_valid, req_ready); end
    step();
    reset = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_after got=%b exp=00", resp_valid); end
    step();
    req_valid = 2'b11; a1 = 32'd1; b1 = 32'd1;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_ptr got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b01 || resp_data !== 32'd9) begin n_fail++; $display("FAIL rmid_resp got=%b/%0d exp=01/9", resp_valid, resp_data); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul_low();
    test_mul_high();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
